// File: rtl/seek_c_pkg.sv
// Shared widths, state encoding and the saturating-add helper for seek_c.
package seek_c_pkg;

    localparam int DATAWIDTH      = 16;
    localparam int SEEK_C_FRAC_W  = 13;
    localparam int SEEK_C_CARRY_W = 2;
    localparam int ACC_W          = SEEK_C_FRAC_W + SEEK_C_CARRY_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Returns {saturated, sum}; the sum pins to all-ones when the true sum exceeds ACC_W bits.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [SEEK_C_FRAC_W-1:0] mag);
        logic [ACC_W:0] wide;
        wide = {1'b0, acc} + {{(ACC_W + 1 - SEEK_C_FRAC_W){1'b0}}, mag};
        if (wide[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = wide;
        end
    endfunction

endpackage

// File: rtl/seek_c_mag.sv
// Sample magnitude extraction for seek_c.
// SEEK_C_ABS_EN defined   : x_in is signed; mag = |x_in| clamped to 0x1FFF.
// SEEK_C_ABS_EN undefined : x_in is unsigned; mag = x_in[12:0].
module seek_c_mag
    import seek_c_pkg::*;
(
    input  logic [DATAWIDTH-1:0]     x_in,
    output logic [SEEK_C_FRAC_W-1:0] mag
);

`ifdef SEEK_C_ABS_EN
    localparam logic [DATAWIDTH-1:0] MAG_MAX = DATAWIDTH'((1 << SEEK_C_FRAC_W) - 1);

    logic [DATAWIDTH-1:0] abs_v;

    // Absolute value, then clamp; 0x8000 negates to itself and clamps to the maximum.
    always_comb begin
        abs_v = x_in[DATAWIDTH-1] ? (~x_in + DATAWIDTH'(1)) : x_in;
        if (abs_v > MAG_MAX) begin
            mag = MAG_MAX[SEEK_C_FRAC_W-1:0];
        end else begin
            mag = abs_v[SEEK_C_FRAC_W-1:0];
        end
    end
`else
    logic x_hi_unused;

    assign mag         = x_in[SEEK_C_FRAC_W-1:0];
    assign x_hi_unused = ^x_in[DATAWIDTH-1:SEEK_C_FRAC_W];
`endif

endmodule

// File: rtl/seek_c.sv
// seek_c: accumulates NTERMS sample magnitudes into a saturating 15-bit frame sum.
// c = {1'b0, acc}; c_vld is a one-cycle pulse meant to drive seek_e.en directly.
// Handshake: x_in is consumed in any ACC cycle where x_vld is high and start is low;
// there is no backpressure, and c is held from its c_vld cycle until the next result.
// Optional feature macro: SEEK_C_ABS_EN (signed magnitude input, handled in seek_c_mag).
module seek_c
    import seek_c_pkg::*;
#(
    parameter int NTERMS = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] x_in,
    input  logic                 x_vld,
    input  logic                 start,
    output logic [DATAWIDTH-1:0] c,
    output logic                 c_vld,
    output logic                 busy,
    output logic                 ovf,
    output logic [1:0]           state_dbg
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NTERMS - 1);

    state_e                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH-1:0]    c_q, c_d;
    logic                    c_vld_q, c_vld_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;

    logic [SEEK_C_FRAC_W-1:0] mag;
    logic [ACC_W:0]           add_res;
    logic [ACC_W-1:0]         acc_next;
    logic                     add_sat;

    seek_c_mag u_mag (
        .x_in (x_in),
        .mag  (mag)
    );

    // Saturating accumulate of the current sample onto the running sum.
    always_comb begin
        add_res  = sat_add(acc_q, mag);
        add_sat  = add_res[ACC_W];
        acc_next = add_res[ACC_W-1:0];
    end

    // Next-state: frame control, sample acceptance and result capture.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        c_vld_d = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ACC: begin
                if (start) begin
                    // Abort: the partial frame is dropped and c keeps the previous result.
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (x_vld) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_sat;
                    if (cnt_q == LAST_CNT) begin
                        c_d     = {{(DATAWIDTH - ACC_W){1'b0}}, acc_next};
                        c_vld_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                // The c_vld pulse is already on the output; a start here chains a new frame.
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs, asynchronously cleared by active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            c_vld_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            c_vld_q <= c_vld_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign c         = c_q;
    assign c_vld     = c_vld_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seek_c.sv
// Bench for seek_c: a 4-term and an 8-term instance, checked against a frame-sum model.
module tb_seek_c;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic [W-1:0] x_in4, x_in8;
    logic         x_vld4, x_vld8;
    logic         start4, start8;
    logic [W-1:0] c4, c8;
    logic         c_vld4, c_vld8;
    logic         busy4, busy8;
    logic         ovf4, ovf8;
    logic [1:0]   st4, st8;

    int checks;
    int errors;
    int pulse_cnt4;
    int pulse_cnt8;
    logic [W-1:0] exp_q[$];

    seek_c #(.NTERMS(4), .CNT_W(8)) dut4 (
        .clk(clk), .reset(reset), .x_in(x_in4), .x_vld(x_vld4), .start(start4),
        .c(c4), .c_vld(c_vld4), .busy(busy4), .ovf(ovf4), .state_dbg(st4)
    );

    seek_c #(.NTERMS(8), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .x_in(x_in8), .x_vld(x_vld8), .start(start8),
        .c(c8), .c_vld(c_vld8), .busy(busy8), .ovf(ovf8), .state_dbg(st8)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // c_vld pulses seen at each rising edge
    always @(posedge clk) begin
        if (c_vld4 === 1'b1) pulse_cnt4 = pulse_cnt4 + 1;
        if (c_vld8 === 1'b1) pulse_cnt8 = pulse_cnt8 + 1;
    end

    // ---------------- reference model ----------------
    function automatic int model_mag(input logic [W-1:0] x);
        int v;
`ifdef SEEK_C_ABS_EN
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 8191) v = 8191;
`else
        v = int'(x) % 8192;
`endif
        return v;
    endfunction

    function automatic logic [W-1:0] model_sum(input int total);
        return (total > 32767) ? 16'h7FFF : W'(total);
    endfunction

    // ---------------- driver tasks (enter and leave on a falling edge) ----------------
    task automatic start_4();
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic send_4(input logic [W-1:0] x, input int gap);
        x_in4  = x;
        x_vld4 = 1'b1;
        @(negedge clk);
        x_vld4 = 1'b0;
        x_in4  = $urandom;
        repeat (gap) @(negedge clk);
    endtask

    task automatic start_8();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic send_8(input logic [W-1:0] x, input int gap);
        x_in8  = x;
        x_vld8 = 1'b1;
        @(negedge clk);
        x_vld8 = 1'b0;
        x_in8  = $urandom;
        repeat (gap) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset_init();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (c4 !== 16'h0 || c_vld4 !== 1'b0 || busy4 !== 1'b0 || ovf4 !== 1'b0 || st4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_init: c=%h c_vld=%b busy=%b ovf=%b st=%0d required 0000 0 0 0 0",
                     c4, c_vld4, busy4, ovf4, st4);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int p0;
        logic [W-1:0] hold;
        p0 = pulse_cnt4;
        start_4();
        send_4(16'h0001, 0);
        send_4(16'h0002, 0);
        send_4(16'h0003, 0);
        checks++;
        if (c_vld4 !== 1'b0 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL basic_early: c_vld=%b busy=%b required 0 1", c_vld4, busy4);
        end
        send_4(16'h0004, 0);
        checks++;
        if (c_vld4 !== 1'b1 || c4 !== 16'h000A) begin
            errors++;
            $display("FAIL basic_result: c_vld=%b c=%h required 1 000a", c_vld4, c4);
        end
        hold = c4;
        repeat (4) @(negedge clk);
        checks++;
        if (c_vld4 !== 1'b0 || c4 !== 16'h000A || busy4 !== 1'b0 || pulse_cnt4 - p0 != 1) begin
            errors++;
            $display("FAIL basic_hold: c_vld=%b c=%h busy=%b pulses=%0d required 0 000a 0 1",
                     c_vld4, c4, busy4, pulse_cnt4 - p0);
        end
    endtask

    task automatic test_reset_mid();
        start_4();
        send_4(16'h0010, 0);
        send_4(16'h0020, 0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (c4 !== 16'h0 || c_vld4 !== 1'b0 || busy4 !== 1'b0 || ovf4 !== 1'b0 || st4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: c=%h c_vld=%b busy=%b ovf=%b st=%0d required 0000 0 0 0 0",
                     c4, c_vld4, busy4, ovf4, st4);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_4(16'h0007, 0);
        checks++;
        if (busy4 !== 1'b0 || st4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b st=%0d required 0 0", busy4, st4);
        end
    endtask

    task automatic test_gaps();
        start_4();
        for (int k = 0; k < 4; k++) send_4(16'h1FFF, (k == 3) ? 0 : $urandom_range(0, 3));
        checks++;
        if (c_vld4 !== 1'b1 || c4 !== 16'h7FFC || c4[14:13] !== 2'd3 || ovf4 !== 1'b0) begin
            errors++;
            $display("FAIL gaps: c_vld=%b c=%h ovf=%b required 1 7ffc 0", c_vld4, c4, ovf4);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int p0;
        int total;
        logic [W-1:0] v;
        p0 = pulse_cnt4;
        start_4();
        send_4(16'h0100, 0);
        send_4(16'h0100, 0);
        start_4();
        checks++;
        if (c4 !== 16'h7FFC || c_vld4 !== 1'b0 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold: c=%h c_vld=%b busy=%b required 7ffc 0 1", c4, c_vld4, busy4);
        end
        for (int k = 0; k < 4; k++) send_4(16'h0001, 0);
        checks++;
        if (c_vld4 !== 1'b1 || c4 !== 16'h0004) begin
            errors++;
            $display("FAIL abort_result: c_vld=%b c=%h required 1 0004", c_vld4, c4);
        end
        @(negedge clk);
        checks++;
        if (pulse_cnt4 - p0 != 1) begin
            errors++;
            $display("FAIL abort_pulses: got %0d required 1", pulse_cnt4 - p0);
        end
        // start together with a sample in IDLE: that sample is excluded
        start4 = 1'b1; x_vld4 = 1'b1; x_in4 = 16'h0005;
        @(negedge clk);
        start4 = 1'b0; x_vld4 = 1'b0;
        total = 0;
        for (int k = 0; k < 4; k++) begin
            v = W'($urandom_range(0, 255));
            total += model_mag(v);
            send_4(v, 0);
        end
        checks++;
        if (c_vld4 !== 1'b1 || c4 !== model_sum(total)) begin
            errors++;
            $display("FAIL start_with_sample: c_vld=%b c=%h required 1 %h", c_vld4, c4, model_sum(total));
        end
        @(negedge clk);
    endtask

    task automatic test_idle_ignore();
        int p0;
        p0 = pulse_cnt4;
        for (int k = 0; k < 6; k++) send_4(W'($urandom), 0);
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b0 || pulse_cnt4 != p0 || c_vld4 !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: busy=%b pulses=%0d c_vld=%b required 0 0 0",
                     busy4, pulse_cnt4 - p0, c_vld4);
        end
    endtask

    task automatic test_back_to_back();
        start_4();
        for (int k = 0; k < 4; k++) send_4(16'h0010, 0);
        // start lands in the OUT cycle; the pulse still completes
        checks++;
        if (c_vld4 !== 1'b1 || c4 !== 16'h0040) begin
            errors++;
            $display("FAIL b2b_first: c_vld=%b c=%h required 1 0040", c_vld4, c4);
        end
        start_4();
        checks++;
        if (c_vld4 !== 1'b0 || busy4 !== 1'b1 || st4 !== 2'd1) begin
            errors++;
            $display("FAIL b2b_restart: c_vld=%b busy=%b st=%0d required 0 1 1", c_vld4, busy4, st4);
        end
        for (int k = 0; k < 4; k++) send_4(16'h0003, 0);
        checks++;
        if (c_vld4 !== 1'b1 || c4 !== 16'h000C) begin
            errors++;
            $display("FAIL b2b_second: c_vld=%b c=%h required 1 000c", c_vld4, c4);
        end
        @(negedge clk);
    endtask

    task automatic test_mag();
        logic [W-1:0] xs [4];
        logic [W-1:0] expv;
        xs[0] = 16'hFFFF; xs[1] = 16'h8000; xs[2] = 16'h0003; xs[3] = 16'h0000;
`ifdef SEEK_C_ABS_EN
        expv = 16'h2003;
`else
        expv = 16'h2002;
`endif
        start_4();
        for (int k = 0; k < 4; k++) send_4(xs[k], 0);
        checks++;
        if (c_vld4 !== 1'b1 || c4 !== expv) begin
            errors++;
            $display("FAIL mag: c_vld=%b c=%h required 1 %h", c_vld4, c4, expv);
        end
        @(negedge clk);
    endtask

    task automatic test_random4();
        int total;
        logic [W-1:0] v;
        logic [W-1:0] expv;
        for (int f = 0; f < 25; f++) begin
            start_4();
            total = 0;
            for (int k = 0; k < 4; k++) begin
                v = W'($urandom);
                total += model_mag(v);
                send_4(v, (k == 3) ? 0 : $urandom_range(0, 2));
            end
            exp_q.push_back(model_sum(total));
            expv = exp_q.pop_front();
            checks++;
            if (c_vld4 !== 1'b1 || c4 !== expv || ovf4 !== 1'b0) begin
                errors++;
                $display("FAIL rand4 frame %0d: c_vld=%b c=%h ovf=%b required 1 %h 0",
                         f, c_vld4, c4, ovf4, expv);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_ovf8();
        int total;
        logic [W-1:0] v;
        logic [W-1:0] expv;
        start_8();
        for (int k = 0; k < 8; k++) send_8(16'h1FFF, 0);
        checks++;
        if (c_vld8 !== 1'b1 || c8 !== 16'h7FFF || ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf8: c_vld=%b c=%h ovf=%b required 1 7fff 1", c_vld8, c8, ovf8);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf8_sticky: ovf=%b required 1", ovf8);
        end
        start_8();
        checks++;
        if (ovf8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf8_clear: ovf=%b busy=%b required 0 1", ovf8, busy8);
        end
        for (int f = 0; f < 12; f++) begin
            if (f != 0) start_8();
            total = 0;
            for (int k = 0; k < 8; k++) begin
                v = W'($urandom);
                total += model_mag(v);
                send_8(v, (k == 7) ? 0 : $urandom_range(0, 1));
            end
            exp_q.push_back(model_sum(total));
            expv = exp_q.pop_front();
            checks++;
            if (c_vld8 !== 1'b1 || c8 !== expv || ovf8 !== (total > 32767)) begin
                errors++;
                $display("FAIL rand8 frame %0d: c_vld=%b c=%h ovf=%b required 1 %h %b",
                         f, c_vld8, c8, ovf8, expv, (total > 32767));
            end
            @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0; errors = 0; pulse_cnt4 = 0; pulse_cnt8 = 0;
        reset = 1'b0;
        x_in4 = '0; x_vld4 = 1'b0; start4 = 1'b0;
        x_in8 = '0; x_vld8 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        test_reset_init();
        test_basic();
        test_reset_mid();
        test_gaps();
        test_abort();
        test_idle_ignore();
        test_back_to_back();
        test_mag();
        test_random4();
        test_ovf8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
